// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the integer ALU datapath.
// addsub_op_t selects the adder/subtractor operation; nzcv_t groups the
// condition flags in ARM order.
package alu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    ADC = 2'd2,
    SBC = 2'd3
  } addsub_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/cla_slice.sv
// cla_slice: combinational GROUP-bit carry-lookahead slice.
// Every internal carry is a flat sum-of-products of generate/propagate terms
// back to cin_i, so no carry ripples through earlier bits of the slice.
// c_msb_o is the carry into the top bit, used for signed overflow.
module cla_slice #(
  parameter int GROUP = 16
) (
  input  logic [GROUP-1:0] a_i,
  input  logic [GROUP-1:0] b_i,
  input  logic             cin_i,
  output logic [GROUP-1:0] sum_o,
  output logic             cout_o,
  output logic             c_msb_o,
  output logic             zero_o
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;
  logic             run_p;

  assign g = a_i & b_i;
  assign p = a_i | b_i;

  // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin.
  always_comb begin
    c     = '0;
    run_p = 1'b0;
    c[0]  = cin_i;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = g[i];
      run_p  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (run_p & g[j]);
        run_p  = run_p & p[j];
      end
      c[i+1] = c[i+1] | (run_p & cin_i);
    end
  end

  assign sum_o   = a_i ^ b_i ^ c[GROUP-1:0];
  assign cout_o  = c[GROUP];
  assign c_msb_o = c[GROUP-1];
  assign zero_o  = ~|sum_o;

endmodule

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: WIDTH-bit adder/subtractor built from GROUP-bit
// lookahead slices, one slice per pipeline stage (STAGES = WIDTH/GROUP).
// Stage k adds slice k using the carry registered by stage k-1; upper operand
// slices ride forward in delay registers and finished low sum slices ride
// alongside, so the last stage holds a fully aligned result.
// Build option: define CLA_ADDSUB_FLAGS_EN to generate N, Z and V (with the
// zero-accumulation registers); otherwise those flags are tied to 0.
//
// Handshake: a transaction is accepted when in_valid & in_ready and a result
// is consumed when out_valid & out_ready. All stages advance together when
// advance = ~out_valid | out_ready; in_ready equals advance combinationally,
// so a stalled output freezes the whole pipe (bubbles are kept, not squeezed).
module pipelined_cla_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int GROUP = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int STAGES = (GROUP >= 1) ? WIDTH / GROUP : 1;
  localparam int LAST   = STAGES - 1;

  if (GROUP < 1 || (WIDTH % ((GROUP >= 1) ? GROUP : 1)) != 0) begin : g_bad_cfg
    $error("pipelined_cla_addsub: WIDTH must be a positive multiple of GROUP");
  end

  addsub_op_t       op_e;
  logic [WIDTH-1:0] b_eff;
  logic             cin0;
  logic             advance;

  // Per-stage registers (_q) and their next-state values (_d).
  logic             vld_q [STAGES];
  logic             cry_q [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] bx_q  [STAGES];
  logic             vld_d [STAGES];
  logic             cin_d [STAGES];
  logic [WIDTH-1:0] sum_up[STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] bx_d  [STAGES];

  logic [GROUP-1:0]  sl_sum [STAGES];
  logic [STAGES-1:0] sl_cout;
  logic [STAGES-1:0] sl_cmsb;
  logic [STAGES-1:0] sl_zero;
  nzcv_t             flags;

  assign op_e = addsub_op_t'(op);

  // Operand conditioning: subtraction is a + ~b + carry-in (C=1 means no borrow).
  always_comb begin
    b_eff = b;
    cin0  = 1'b0;
    case (op_e)
      ADD:     begin b_eff = b;  cin0 = 1'b0; end
      SUB:     begin b_eff = ~b; cin0 = 1'b1; end
      ADC:     begin b_eff = b;  cin0 = c_in; end
      SBC:     begin b_eff = ~b; cin0 = c_in; end
      default: begin b_eff = b;  cin0 = 1'b0; end
    endcase
  end

  assign out_valid = vld_q[LAST];
  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign vld_d[k]  = in_valid;
      assign cin_d[k]  = cin0;
      assign sum_up[k] = '0;
      assign a_d[k]    = a;
      assign bx_d[k]   = b_eff;
    end else begin : g_body
      assign vld_d[k]  = vld_q[k-1];
      assign cin_d[k]  = cry_q[k-1];
      assign sum_up[k] = sum_q[k-1];
      assign a_d[k]    = a_q[k-1];
      assign bx_d[k]   = bx_q[k-1];
    end

    cla_slice #(.GROUP(GROUP)) u_slice (
      .a_i     (a_d[k][k*GROUP +: GROUP]),
      .b_i     (bx_d[k][k*GROUP +: GROUP]),
      .cin_i   (cin_d[k]),
      .sum_o   (sl_sum[k]),
      .cout_o  (sl_cout[k]),
      .c_msb_o (sl_cmsb[k]),
      .zero_o  (sl_zero[k])
    );

    // Merge this stage's freshly computed slice into the travelling sum.
    assign sum_d[k] = (sum_up[k] & ~(WIDTH'({GROUP{1'b1}}) << (k*GROUP)))
                    | (WIDTH'(sl_sum[k]) << (k*GROUP));

    // Stage register: loads only when the whole pipe advances.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q[k] <= 1'b0;
        cry_q[k] <= 1'b0;
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        bx_q[k]  <= '0;
      end else if (advance) begin
        vld_q[k] <= vld_d[k];
        cry_q[k] <= sl_cout[k];
        sum_q[k] <= sum_d[k];
        a_q[k]   <= a_d[k];
        bx_q[k]  <= bx_d[k];
      end
    end
  end

`ifdef CLA_ADDSUB_FLAGS_EN
  logic z_q [STAGES];
  logic v_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_zero
    logic z_d;
    if (k == 0) begin : g_head
      assign z_d = sl_zero[k];
    end else begin : g_body
      assign z_d = z_q[k-1] & sl_zero[k];
    end

    // Zero flag accumulates one slice per stage alongside the sum.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        z_q[k] <= 1'b0;
      end else if (advance) begin
        z_q[k] <= z_d;
      end
    end
  end

  // Signed overflow comes from the top slice only: carry into vs out of the MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= 1'b0;
    end else if (advance) begin
      v_q <= sl_cmsb[LAST] ^ sl_cout[LAST];
    end
  end

  assign flags.n = sum_q[LAST][WIDTH-1];
  assign flags.z = z_q[LAST];
  assign flags.v = v_q;
`else
  assign flags.n = 1'b0;
  assign flags.z = 1'b0;
  assign flags.v = 1'b0;
`endif

  assign flags.c = cry_q[LAST];

  // Slice outputs only some stages need, and the last stage's spent operands.
  logic slice_unused;
  assign slice_unused = ^{sl_cmsb, sl_zero, a_q[LAST], bx_q[LAST]};

  assign sum    = sum_q[LAST];
  assign flag_n = flags.n;
  assign flag_z = flags.z;
  assign flag_c = flags.c;
  assign flag_v = flags.v;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb_pipelined_cla_addsub: directed vectors with hand-computed results for the
// 64/16 configuration, streamed back-to-back, then an output-stall scenario
// and a reset-while-busy scenario.
module tb_pipelined_cla_addsub;

  localparam int W = 64;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_ADC = 2'd2;
  localparam logic [1:0] OP_SBC = 2'd3;
`ifdef CLA_ADDSUB_FLAGS_EN
  localparam logic [3:0] FMASK = 4'b1111;
`else
  localparam logic [3:0] FMASK = 4'b0010;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic         c_in;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         flag_n;
  logic         flag_z;
  logic         flag_c;
  logic         flag_v;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_out = 0;
  int out_before;

  // Scoreboard: {sum, nzcv} per accepted op, and its acceptance cycle (-1 = no latency check).
  logic [W+3:0] exp_q[$];
  int           acc_q[$];
  logic [W+3:0] drv_exp;
  bit           drv_lat;

  pipelined_cla_addsub #(.WIDTH(64), .GROUP(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .c_in      (c_in),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver: present one op from posedge+1 and hold it until accepted.
  task automatic send(input logic [1:0] o, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic ci, input logic [W-1:0] es, input logic [3:0] ef, input bit lat);
    int n;
    op       = o;
    a        = ta;
    b        = tb_v;
    c_in     = ci;
    drv_exp  = {es, ef};
    drv_lat  = lat;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    check_eq("accept", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, W'(exp_q.size()), W'(0));
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    logic [W+3:0] e;
    int t;
    if (!reset) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(drv_exp);
        acc_q.push_back(drv_lat ? cyc : -1);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got=%h exp=none", sum);
        end else begin
          e = exp_q.pop_front();
          t = acc_q.pop_front();
          check_eq("sum", sum, e[W+3:4]);
          check_eq("nzcv", W'({flag_n, flag_z, flag_c, flag_v}), W'(e[3:0] & FMASK));
          if (t >= 0) check_eq("latency", W'(cyc - t), W'(4));
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = OP_ADD;
    c_in      = 1'b0;
    a         = '0;
    b         = '0;
    drv_exp   = '0;
    drv_lat   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", W'(out_valid), W'(0));
    check_eq("rst_in_ready", W'(in_ready), W'(1));
    check_eq("rst_sum", sum, W'(0));
    check_eq("rst_flags", W'({flag_n, flag_z, flag_c, flag_v}), W'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors, back-to-back, out_ready held high (latency checked on each).
    send(OP_ADD, 64'h1F0, 64'h15, 1'b0, 64'h205, 4'b0000, 1'b1);
    send(OP_SUB, 64'h1F0, 64'h15, 1'b0, 64'h1DB, 4'b0010, 1'b1);
    send(OP_SBC, 64'h1F0, 64'h15, 1'b0, 64'h1DA, 4'b0010, 1'b1);
    send(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 4'b0110, 1'b1);
    send(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001, 1'b1);
    send(OP_SUB, 64'h15, 64'h1F0, 1'b0, 64'hFFFF_FFFF_FFFF_FE25, 4'b1000, 1'b1);
    send(OP_ADC, 64'hFFFF, 64'h0, 1'b1, 64'h1_0000, 4'b0000, 1'b1);
    send(OP_SUB, 64'h1234, 64'h1234, 1'b0, 64'h0, 4'b0110, 1'b1);
    send(OP_SUB, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1'b1);
    send(OP_ADC, 64'h0000_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0001_0000_0000_0000, 4'b0000, 1'b1);
    send(OP_SBC, 64'h0, 64'h0, 1'b1, 64'h0, 4'b0110, 1'b1);
    send(OP_ADD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 4'b0111, 1'b1);
    wait_drain("drain_directed");

    // Stall: 6 back-to-back ops, out_ready low for 3 cycles once the first result shows.
    out_before = n_out;
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(OP_ADD, W'(i) * 64'h1000, W'(i), 1'b0, W'(i) * 64'h1001, 4'b0000, 1'b0);
      end
      begin
        int n;
        n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!out_valid && n < 50);
        check_eq("stall_first_valid", W'(out_valid), W'(1));
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check_eq("stall_in_ready", W'(in_ready), W'(0));
          check_eq("stall_out_valid", W'(out_valid), W'(1));
          check_eq("stall_sum", sum, 64'h1001);
          check_eq("stall_flags", W'({flag_n, flag_z, flag_c, flag_v}), W'(0));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("drain_stall");
    check_eq("stall_count", W'(n_out - out_before), W'(6));

    // Reset with one result waiting and three ops in flight.
    out_ready = 1'b0;
    send(OP_ADD, 64'h11, 64'h22, 1'b0, 64'h33, 4'b0000, 1'b0);
    send(OP_ADD, 64'h44, 64'h55, 1'b0, 64'h99, 4'b0000, 1'b0);
    send(OP_SUB, 64'h10, 64'h20, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 4'b1000, 1'b0);
    send(OP_ADD, 64'h1, 64'h2, 1'b0, 64'h3, 4'b0000, 1'b0);
    check_eq("pre_reset_valid", W'(out_valid), W'(1));
    check_eq("pre_reset_sum", sum, 64'h33);
    reset = 1'b1;
    #1;
    check_eq("reset_out_valid", W'(out_valid), W'(0));
    check_eq("reset_sum", sum, W'(0));
    check_eq("reset_flags", W'({flag_n, flag_z, flag_c, flag_v}), W'(0));
    check_eq("reset_in_ready", W'(in_ready), W'(1));
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check_eq("stale_valid", W'(out_valid), W'(0));
    end
    @(posedge clk);
    #1;
    send(OP_ADD, 64'h1F0, 64'h15, 1'b0, 64'h205, 4'b0000, 1'b1);
    wait_drain("drain_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_addsub.md
# pipelined_cla_addsub

Parametrised, pipelined carry-lookahead adder/subtractor with ARM-style carry-in modes and NZCV flag generation. The WIDTH-bit operation is split into GROUP-bit lookahead slices, one slice per pipeline stage, with the carry registered between stages. A valid/ready handshake lets the block sit between the register-read stage and the ALU result mux of the 64-bit datapath, and it absorbs downstream stalls.

## Interface
- WIDTH, 64, operand/result width in bits
- GROUP, 16, bits per lookahead slice (= per pipeline stage); WIDTH % GROUP must be 0
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operands/op present
- in_ready  out  1  block accepts this cycle
- op  in  2  ADD=0, SUB=1, ADC=2, SBC=3 (alu_pkg::addsub_op_t)
- c_in  in  1  carry flag input for ADC/SBC
- a, b  in  WIDTH  operands
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts this cycle
- sum  out  WIDTH  result
- flag_n, flag_z, flag_c, flag_v  out  1 each  negative, zero, carry-out, signed overflow

## Operation
- STAGES = WIDTH/GROUP. Effective b' = b inverted for SUB/SBC, else b. Carry into bit 0: ADD 0, SUB 1, ADC/SBC c_in.
- Per slice: g = a&b', p = a|b', c[i+1] = g[i] | p[i]&c[i] (full lookahead across the slice, no ripple), sum[i] = a^b'^c[i].
- Stage k computes slice k from the carry registered by stage k-1. Operand slices for later stages travel in delay registers; completed sum slices for earlier stages travel forward alongside. The output is fully aligned.
- flag_c = carry out of bit WIDTH-1. flag_v = c[WIDTH-1] ^ c[WIDTH]. flag_n = sum[WIDTH-1]. flag_z = AND of per-slice zero bits, accumulated stage by stage.
- SUB/SBC carry follows the ARM convention: C=1 means no borrow.
- Each stage carries a valid bit. Global advance = ~out_valid | out_ready. in_ready = advance (combinational). All stage registers load only when advance=1. Bubbles are not collapsed.
- A transaction is accepted when in_valid & in_ready. A result is consumed when out_valid & out_ready.

## Timing
- Latency STAGES cycles from acceptance to out_valid (64/16: 4 cycles). STAGES=1 gives 1 cycle.
- Throughput is 1 per cycle while out_ready=1.
- When out_valid=1 and out_ready=0, all stages freeze. sum and flags hold stable, and in_ready=0 in the same cycle.
- out_valid & out_ready with a new in_valid in the same cycle: pop and push both occur, and the pipeline shifts.
- Reset (async) clears every valid bit, sum, flags and the inter-stage carry registers to 0 immediately. In-flight transactions are discarded. After reset, in_ready=1.
- Output registers are the last-stage registers, with no combinational path from a/b to outputs.
- Wrap-around: the result is modulo 2^WIDTH, with overflow reported only via flags.

## Configuration
- CLA_ADDSUB_FLAGS_EN defined: flag_n, flag_z and flag_v are generated as above, including the zero-accumulation registers.
- CLA_ADDSUB_FLAGS_EN undefined: flag_n, flag_z and flag_v are tied 0 and their registers are removed. sum, flag_c and the handshake are unchanged. The port list is identical in both builds.

## Structure
- alu_pkg: addsub_op_t enum (ADD, SUB, ADC, SBC) and the nzcv_t packed struct. The pkg does not hold WIDTH/GROUP defaults; those are module parameters.
- Sub-module cla_slice #(GROUP): combinational. Inputs: a, b', cin. Outputs: sum slice, cout, c_into_msb (used for V in the top slice), slice_zero. Instantiate one per stage in a generate loop.
- Top level: handshake/advance logic, skew delay registers, valid chain and flag assembly.
- Elaboration check: fail if WIDTH % GROUP != 0 or GROUP < 1.

## Test plan
- ADD a=0x1F0, b=0x15 -> after 4 cycles: sum=0x205, NZCV=0000.
- SUB a=0x1F0, b=0x15 -> sum=0x1DB, C=1, N=Z=V=0. Then SBC with the same operands and c_in=0 -> sum=0x1DA, C=1.
- ADD 0xFFFF_FFFF_FFFF_FFFF + 1 -> sum=0, Z=1, C=1, V=0. This exercises carry across all three stage boundaries.
- ADD 0x7FFF_FFFF_FFFF_FFFF + 1 -> sum=0x8000_0000_0000_0000, N=1, V=1, C=0.
- Stall check: issue 6 back-to-back ops, hold out_ready=0 for 3 cycles once the first result appears. Expect in_ready=0 while stalled, outputs stable, and all 6 results delivered in order with no loss or duplication.
- Assert reset for 1 cycle while 3 ops are in flight -> out_valid=0 and sum/flags=0 immediately, no stale result afterward, and a new op issued after reset returns correctly 4 cycles later.
